uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter, 8N1 by default.
- Sits directly downstream of the baud generator and consumes its single-cycle baudclk tick, one tick per bit period.
- Bytes are written by the CPU/bus side into a small internal FIFO, then shifted out on txd LSB-first with one start bit and one stop bit.
- Reports FIFO status and a sticky overflow flag back to the bus-side register logic.

Parameters:
- DATA_BITS, 8: data bits per frame, legal range 5..8.
- FIFO_DEPTH, 4: FIFO entries; power of two, minimum 2.
- FIFO_AW, 2: log2(FIFO_DEPTH); must be kept consistent with FIFO_DEPTH.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- baudclk, input, 1: single-cycle bit-rate tick from the baud generator.
- we, input, 1: write strobe; pushes data_in when not full.
- data_in, input, DATA_BITS: byte to transmit.
- clr_ovf, input, 1: clears the ovf flag.
- txd, output, 1: serial line out; idle high.
- full, output, 1: FIFO holds FIFO_DEPTH entries.
- empty, output, 1: FIFO holds 0 entries.
- count, output, FIFO_AW+1: FIFO occupancy.
- busy, output, 1: frame in progress or FIFO not empty.
- ovf, output, 1: sticky flag; a write occurred while full.

Behaviour:
- Reset (synchronous, takes effect at the clock edge where reset=1):
  - txd=1, state=IDLE, FIFO flushed (rd/wr pointers=0, count=0).
  - full=0, empty=1, busy=0, ovf=0.
  - Reset mid-frame aborts the frame; txd is 1 from the following cycle; all queued bytes are lost.
- FIFO:
  - Registered pointers; full, empty and count are registered, derived from count.
  - Write is accepted when we=1 and full=0 at that edge; count increments.
  - we=1 with full=1: data dropped and ovf set to 1. This holds even if a pop happens on the same edge, because full is evaluated before the pop.
  - Pop happens only on a baudclk edge where the state machine starts a frame and count was non-zero before that edge.
  - Simultaneous write and pop: count unchanged; both take effect.
  - Write into an empty FIFO is not available for pop until the next edge; no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- ovf:
  - Set by a dropped write, cleared by clr_ovf.
  - If both occur on the same edge, set wins.
- State machine, advancing only on edges where baudclk=1 (nothing changes otherwise):
  - IDLE: txd=1. On tick with empty=0: load the FIFO head into shift register, pop, txd<=0, go to START.
  - START: on tick: txd<=shift[0], shift right by 1, bitcnt<=0, go to DATA.
  - DATA: on tick: if bitcnt==DATA_BITS-1 then txd<=1 and go to STOP; else txd<=shift[0], shift right, bitcnt<=bitcnt+1.
  - STOP: on tick: if empty=0, pop, load, txd<=0 and go to START (back-to-back, no idle gap); else txd<=1 and go to IDLE.
- Frame timing:
  - Each line level lasts exactly one tick period; an 8N1 frame spans 10 tick periods.
  - Latency from write to start bit: up to one tick period, since a frame starts only on the next tick edge.
- busy = (state!=IDLE) | (empty=0), registered-equivalent (no combinational path from we).
- txd is driven directly from a flop, so the serial line is glitch-free.
- baudclk held high for consecutive cycles is treated as one tick per cycle; no edge detection. The upstream tick is guaranteed single-cycle.

Test Plan:
- Reset, then bench pulses baudclk every 4 clk. Write 0xA5 → txd sequence per tick: 0 (start), 1,0,1,0,0,1,0,1 (LSB-first), 1 (stop), then idle 1. busy falls after the stop tick; empty=1.
- Write 0x00 and 0xFF on consecutive cycles → two frames back-to-back. The stop bit of the first is followed by the start bit of the second on the next tick with no idle gap. count goes 1→2, then 1, then 0.
- Five writes with FIFO_DEPTH=4 and no baudclk → full=1 after the 4th, ovf=1 after the 5th. count=4 and the 5th byte is never transmitted. Pulse clr_ovf → ovf=0.
- FIFO full with a pop tick on the same edge as we=1 → write dropped, ovf=1, count=3 afterwards.
- Assert reset during the DATA state of a 0x3C frame → txd=1, count=0, busy=0 on the next cycle. No further transitions on subsequent ticks until a new write.
- baudclk held low for 1000 cycles after a write → txd stays 1 and state stays IDLE; the frame begins on the first tick.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with write FIFO; ports clk/reset/baudclk/we/data_in/clr_ovf in, txd/full/empty/count/busy/ovf out
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baudclk,
  input  logic                 we,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 clr_ovf,
  output logic                 txd,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_AW:0]     count,
  output logic                 busy,
  output logic                 ovf
);
  localparam int BW = $clog2(DATA_BITS);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [BW-1:0] bitcnt, bitcnt_n;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count_n;
  logic txd_n, push, pop;
  assign push = we & ~full;
  assign pop = baudclk & ~empty & (state == IDLE | state == STOP);
  assign busy = state != IDLE | ~empty;
  always_comb begin
    count_n = push & ~pop ? count + 1'b1 : ~push & pop ? count - 1'b1 : count;
  end
  always_comb begin
    state_n = state;
    txd_n = txd;
    shift_n = shift;
    bitcnt_n = bitcnt;
    if (pop) begin
      state_n = START;
      shift_n = mem[rd_ptr];
      txd_n = 1'b0;
    end else if (baudclk) begin
      case (state)
        START: begin
          txd_n = shift[0];
          shift_n = shift >> 1;
          bitcnt_n = '0;
          state_n = DATA;
        end
        DATA: begin
          txd_n = bitcnt == BW'(DATA_BITS - 1) ? 1'b1 : shift[0];
          shift_n = shift >> 1;
          bitcnt_n = bitcnt + 1'b1;
          state_n = bitcnt == BW'(DATA_BITS - 1) ? STOP : DATA;
        end
        STOP: begin
          txd_n = 1'b1;
          state_n = IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      txd <= 1'b1;
      shift <= '0;
      bitcnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      ovf <= 1'b0;
    end else begin
      txd <= txd_n;
      shift <= shift_n;
      bitcnt <= bitcnt_n;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count_n;
      full <= count_n == (FIFO_AW + 1)'(FIFO_DEPTH);
      empty <= count_n == '0;
      ovf <= (we & full) | (ovf & ~clr_ovf);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench for uart_tx against a frame-position reference model
module tb_uart_tx;
  logic clk = 0, reset = 0, baudclk = 0, we = 0, clr_ovf = 0;
  logic [7:0] data_in = 0;
  logic txd, full, empty, busy, ovf;
  logic [2:0] count;
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [7:0] fifo_m[$], exp_q[$];
  logic [7:0] cur = 0;
  int pos = -1;
  bit ovf_m = 0;
  bit tick_s = 0;
  int dpos = -1;
  logic [7:0] dbyte;

  uart_tx #(.DATA_BITS(8), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .baudclk(baudclk), .we(we), .data_in(data_in),
    .clr_ovf(clr_ovf), .txd(txd), .full(full), .empty(empty), .count(count),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: decode frames from txd one tick at a time and retire them from the scoreboard.
  always @(posedge clk) begin
    tick_s = baudclk && !reset;
    if (reset) dpos = -1;
  end
  always @(negedge clk) begin
    if (tick_s) begin
      if (dpos == -1) begin
        if (txd === 1'b0) dpos = 0;
      end else if (dpos < 8) begin
        dbyte[dpos] = txd;
        dpos++;
      end else begin
        chk("stop_bit", 32'(txd), 32'd1);
        if (exp_q.size() == 0) chk("unexpected_frame", 32'(dbyte), 32'hffff_ffff);
        else chk("frame_byte", 32'(dbyte), 32'(exp_q.pop_front()));
        dpos = -1;
      end
    end
  end

  // Reference model: a frame is a 10-slot sequence (0 start, 1..8 data, 9 stop), -1 means line idle.
  task automatic step(bit w, logic [7:0] d, bit bc, bit clr, bit rs);
    bit full_m, pop, tx_m;
    we = w; data_in = d; baudclk = bc; clr_ovf = clr; reset = rs;
    @(posedge clk);
    cyc++;
    if (rs) begin
      fifo_m.delete(); exp_q.delete(); pos = -1; ovf_m = 0;
    end else begin
      full_m = fifo_m.size() == 4;
      pop = bc && (pos == -1 || pos == 9) && fifo_m.size() > 0;
      if (bc) begin
        if (pop) begin cur = fifo_m.pop_front(); pos = 0; end
        else if (pos == 9) pos = -1;
        else if (pos != -1) pos++;
      end
      if (w && !full_m) begin fifo_m.push_back(d); exp_q.push_back(d); end
      if (w && full_m) ovf_m = 1;
      else if (clr) ovf_m = 0;
    end
    @(negedge clk);
    tx_m = (pos == -1 || pos == 9) ? 1'b1 : pos == 0 ? 1'b0 : cur[pos-1];
    chk("txd", 32'(txd), 32'(tx_m));
    chk("count", 32'(count), 32'(fifo_m.size()));
    chk("full", 32'(full), 32'(fifo_m.size() == 4));
    chk("empty", 32'(empty), 32'(fifo_m.size() == 0));
    chk("busy", 32'(busy), 32'(pos != -1 || fifo_m.size() > 0));
    chk("ovf", 32'(ovf), 32'(ovf_m));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step(0, 0, (cyc % 4) == 3, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    run(8);
    step(1, 8'hA5, 0, 0, 0);
    run(60);
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0);
    run(100);
    for (int i = 0; i < 5; i++) step(1, 8'h10 + 8'(i), 0, 0, 0);
    step(0, 0, 0, 1, 0);
    run(200);
    for (int i = 0; i < 4; i++) step(1, 8'h60 + 8'(i), 0, 0, 0);
    step(1, 8'h77, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    run(200);
    step(1, 8'h3C, 0, 0, 0);
    run(14);
    step(0, 0, 0, 0, 1);
    run(40);
    step(1, 8'hC3, 0, 0, 0);
    for (int i = 0; i < 1000; i++) step(0, 0, 0, 0, 0);
    run(60);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(2) == 0, 8'($urandom), $urandom_range(3) == 0, $urandom_range(40) == 0, 0);
    run(300);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("monitor_idle", 32'(dpos), 32'hffff_ffff);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
